// File: rtl/hdmi_data_island_packetizer_if.sv
// Packet input bus of the data-island packetizer: one header plus four
// subpackets handed over with a valid/ready handshake.
interface hdmi_data_island_packetizer_if;
  // A packet transfers on the CLK_PIXEL edge where in_valid and in_ready are
  // both high; header/sub*/first_in_island are sampled only on that edge and
  // must be stable while in_valid is high. in_ready never waits on in_valid.
  logic        in_valid;
  logic        in_ready;
  logic        first_in_island;
  logic [23:0] header;
  logic [55:0] sub0;
  logic [55:0] sub1;
  logic [55:0] sub2;
  logic [55:0] sub3;

  modport master (
    output in_valid, first_in_island, header, sub0, sub1, sub2, sub3,
    input  in_ready
  );

  modport slave (
    input  in_valid, first_in_island, header, sub0, sub1, sub2, sub3,
    output in_ready
  );
endinterface

// File: rtl/hdmi_data_island_packetizer.sv
// Serialises one HDMI data-island packet over 32 pixel clocks into the three
// TERC4 source nibbles, computing the BCH parity bytes on the fly.
module hdmi_data_island_packetizer #(
    parameter bit         ECC_EN   = 1'b1,
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic                                CLK_PIXEL,
    input  logic                                RESET_N,
    hdmi_data_island_packetizer_if.slave        pkt,
    input  logic                                hsync,
    input  logic                                vsync,
    output logic [3:0]                          ch0,
    output logic [3:0]                          ch1,
    output logic [3:0]                          ch2,
    output logic                                pkt_active,
    output logic [0:0]                          dbg_state,
    output logic [4:0]                          dbg_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]  state_q;
    logic [4:0]  cnt_q;
    logic [23:0] hdr_q;
    logic [55:0] sub_q [4];
    logic        first_q;
    logic [7:0]  hp_q;
    logic [7:0]  sp_q [4];

    logic        accept;
    logic        last_clk;
    logic        hdr_bit;
    logic [7:0]  hp_n;
    logic [7:0]  sp_n [4];
    logic [3:0]  lo_n;
    logic [3:0]  hi_n;

    // One serial step of the reflected BCH LFSR.
    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
        logic fb;
        fb = p[0] ^ b;
        return (p >> 1) ^ (fb ? ECC_POLY : 8'h00);
    endfunction

    assign last_clk     = (state_q == S_SEND) && (cnt_q == 5'd31);
    assign pkt.in_ready = RESET_N && ((state_q == S_IDLE) || last_clk);
    assign accept       = pkt.in_valid && pkt.in_ready;
    assign dbg_state    = state_q;
    assign dbg_count    = cnt_q;

    // Data bits feed the parity in the same cycle they are sent, so each
    // parity byte is complete exactly on the first clock that transmits it.
    always_comb begin
        hdr_bit = 1'b0;
        hp_n    = hp_q;
        lo_n    = 4'h0;
        hi_n    = 4'h0;
        if (cnt_q < 5'd24) begin
            hdr_bit = hdr_q[cnt_q];
            hp_n    = bch_step(hp_q, hdr_bit);
        end else if (ECC_EN) begin
            hdr_bit = hp_q[cnt_q[2:0]];
        end
        for (int k = 0; k < 4; k++) begin
            sp_n[k] = sp_q[k];
            if (cnt_q < 5'd28) begin
                lo_n[k] = sub_q[k][{cnt_q, 1'b0}];
                hi_n[k] = sub_q[k][{cnt_q, 1'b1}];
                sp_n[k] = bch_step(bch_step(sp_q[k], lo_n[k]), hi_n[k]);
            end else if (ECC_EN) begin
                lo_n[k] = sp_q[k][{cnt_q[1:0], 1'b0}];
                hi_n[k] = sp_q[k][{cnt_q[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            hdr_q      <= 24'h0;
            first_q    <= 1'b0;
            hp_q       <= 8'h00;
            ch0        <= 4'h0;
            ch1        <= 4'h0;
            ch2        <= 4'h0;
            pkt_active <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sub_q[k] <= 56'h0;
                sp_q[k]  <= 8'h00;
            end
        end else begin
            if (state_q == S_SEND) begin
                ch0        <= {~((cnt_q == 5'd0) && first_q), hdr_bit, vsync, hsync};
                ch1        <= lo_n;
                ch2        <= hi_n;
                pkt_active <= 1'b1;
                hp_q       <= hp_n;
                cnt_q      <= cnt_q + 5'd1;
                for (int k = 0; k < 4; k++) sp_q[k] <= sp_n[k];
            end else begin
                ch0        <= {2'b00, vsync, hsync};
                ch1        <= 4'h0;
                ch2        <= 4'h0;
                pkt_active <= 1'b0;
            end

            // A new packet on the last clock follows with no gap.
            if (accept) begin
                state_q  <= S_SEND;
                cnt_q    <= 5'd0;
                hdr_q    <= pkt.header;
                first_q  <= pkt.first_in_island;
                hp_q     <= 8'h00;
                sub_q[0] <= pkt.sub0;
                sub_q[1] <= pkt.sub1;
                sub_q[2] <= pkt.sub2;
                sub_q[3] <= pkt.sub3;
                for (int k = 0; k < 4; k++) sp_q[k] <= 8'h00;
            end else if (last_clk) begin
                state_q <= S_IDLE;
            end
        end
    end

endmodule
